instr_fetch: RTL

Instruction-fetch stage that sits directly upstream of `bank_register` and the decoder in the 16-bit MSP430-style datapath. It fetches 16-bit instruction words from instruction memory over a req/ack handshake and buffers them in a small prefetch queue. It hands words to the decoder with a valid/ready handshake. It keeps the architectural PC in the register file up to date through `bank_register`'s `pc_inc`/`pc_data_in` port.

---
 rtl/instr_fetch_pkg.sv | 33 +++
 rtl/instr_fetch_queue.sv | 67 ++++++
 rtl/instr_fetch.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the 16-bit MSP430-style fetch stage: word width,
// fetch FSM state encoding, PC reset default, register-file r0 index and a
// word-alignment helper. Imported by fetch_queue and instr_fetch.
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    // Matches the pc reset value of bank_register.
    localparam word_t RESET_PC_DEFAULT = 16'h0000;

    // r0 is the architectural PC inside bank_register.
    localparam logic [3:0] R0_IDX = 4'd0;

    // Instruction words are two bytes apart.
    localparam word_t PC_STEP = 16'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,  // no request outstanding
        ST_REQ  = 2'b01,  // request outstanding, data wanted
        ST_DROP = 2'b10   // request outstanding, data to be discarded
    } fetch_state_e;

    // Instruction addresses are always even; bit 0 is forced low.
    function automatic word_t word_align(input word_t addr);
        return {addr[WORD_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// DEPTH-entry prefetch FIFO of instruction words. Push and pop may happen in
// the same cycle (including when full); flush empties the queue and has
// priority over push/pop. The caller never pushes into a full queue without
// also popping, and never pops an empty queue.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i          write push_data_i at the tail
//   push_data_i     word to store
//   pop_i           drop the head word
//   flush_i         discard all entries
//   count_o         number of valid entries (0..DEPTH)
//   head_o          head word, zero while empty
// -----------------------------------------------------------------------------
module fetch_queue
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  word_t            push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output word_t            head_o
);

    word_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // DEPTH is a power of two, so the pointers wrap on their own.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after it
    // was written, and head_o is forced to zero while the queue is empty.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction-fetch stage: requests words from instruction memory (req/ack),
// buffers them in fetch_queue, presents the head word to the decoder
// (valid/ready) and keeps r0 in bank_register current through pc_inc /
// pc_data_in. Branch redirects flush the queue and discard in-flight data.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   imem_req/imem_addr    memory read request and word-aligned address
//   imem_ack/imem_rdata   read completion and returned word
//   ir/ir_valid/ir_ready  decoder handshake for the head word
//   rf_wr_en              bank_register write enable (blocks pc_inc)
//   branch_en/branch_target  one-cycle redirect from control_unit
//   pc_inc/pc_data_in     r0 update to bank_register
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int    DEPTH    = 2,
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    output logic  imem_req,
    output word_t imem_addr,
    input  logic  imem_ack,
    input  word_t imem_rdata,
    output word_t ir,
    output logic  ir_valid,
    input  logic  ir_ready,
    input  logic  rf_wr_en,
    input  logic  branch_en,
    input  word_t branch_target,
    output logic  pc_inc,
    output word_t pc_data_in
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    fetch_state_e     state_q, state_d;
    word_t            fetch_addr_q, fetch_addr_d;  // next address to request
    word_t            req_addr_q, req_addr_d;      // address of outstanding request
    word_t            arch_pc_q, arch_pc_d;        // address of the head word
    logic             pc_pend_q, pc_pend_d;        // r0 write owed to bank_register

    logic [CNT_W-1:0] q_count;
    word_t            q_head;
    logic             q_push;
    logic             consume;
    logic [OCC_W-1:0] occ_next;
    logic             space_ok;
    word_t            target;

    assign target   = word_align(branch_target);
    assign ir_valid = (q_count != '0);
    assign ir       = q_head;

    // A redirect wins over consume; the word is dropped with the flush.
    assign consume  = ir_valid & ir_ready & ~rf_wr_en & ~pc_pend_q & ~branch_en;

    // Data returned during a redirect cycle belongs to the old stream.
    assign q_push   = (state_q == ST_REQ) & imem_ack & ~branch_en;

    // Occupancy after this edge; the outstanding request is accounted for by
    // only issuing from IDLE or on the ack that retires the previous one.
    assign occ_next = OCC_W'(q_count) + OCC_W'(q_push) - OCC_W'(consume);
    assign space_ok = occ_next < OCC_W'(DEPTH);

    // imem_req is a decoded register so it rises one edge after the decision
    // and stays stable until the ack.
    assign imem_req  = (state_q != ST_IDLE);
    assign imem_addr = req_addr_q;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (q_push),
        .push_data_i (imem_rdata),
        .pop_i       (consume),
        .flush_i     (branch_en),
        .count_o     (q_count),
        .head_o      (q_head)
    );

    // Fetch FSM next-state.
    // NOTE: every signal assigned in a combinational block gets a default first
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        req_addr_d   = req_addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (branch_en) begin
                    state_d    = ST_REQ;
                    req_addr_d = target;
                end else if (space_ok) begin
                    state_d    = ST_REQ;
                    req_addr_d = fetch_addr_q;
                end
            end
            ST_REQ: begin
                if (branch_en) begin
                    // Acked now: data discarded, target requested next.
                    // Not acked: the in-flight data must be dropped later.
                    if (imem_ack) req_addr_d = target;
                    else          state_d    = ST_DROP;
                end else if (imem_ack) begin
                    fetch_addr_d = fetch_addr_q + PC_STEP;
                    if (space_ok) req_addr_d = fetch_addr_q + PC_STEP;
                    else          state_d    = ST_IDLE;
                end
            end
            ST_DROP: begin
                // The queue is empty here, so the redirected stream can be
                // requested straight after the discarded ack.
                if (imem_ack) begin
                    state_d    = ST_REQ;
                    req_addr_d = branch_en ? target : fetch_addr_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (branch_en) fetch_addr_d = target;
    end

    // Architectural PC and r0 update pulse.
    always_comb begin
        arch_pc_d  = arch_pc_q;
        pc_pend_d  = pc_pend_q & rf_wr_en;
        pc_inc     = 1'b0;
        pc_data_in = arch_pc_q;

        if (branch_en) begin
            // bank_register ignores pc_inc while it is being written, so the
            // target write is deferred until rf_wr_en drops.
            arch_pc_d  = target;
            pc_pend_d  = rf_wr_en;
            pc_inc     = ~rf_wr_en;
            pc_data_in = target;
        end else if (pc_pend_q) begin
            pc_inc = ~rf_wr_en;
        end else if (consume) begin
            arch_pc_d  = arch_pc_q + PC_STEP;
            pc_inc     = 1'b1;
            pc_data_in = arch_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            fetch_addr_q <= RESET_PC;
            req_addr_q   <= RESET_PC;
            arch_pc_q    <= RESET_PC;
            pc_pend_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            req_addr_q   <= req_addr_d;
            arch_pc_q    <= arch_pc_d;
            pc_pend_q    <= pc_pend_d;
        end
    end

endmodule
